// File: rtl/pwr_domain_seq.sv
// -----------------------------------------------------------------------------
// pwr_domain_seq
//   Sequences one switchable power domain so that it follows the 2-bit SoC
//   power state requested by the power controller. Clock gate, isolation,
//   retention save/restore and the power switch are driven in a safe order,
//   and the switch acknowledge is awaited with a timeout.
//
//   Power states (target_state / current_state):
//     00 SHUTDOWN   rail off, no retention
//     01 DEEPSLEEP  rail off, retention flops hold state
//     10 SLEEP      rail on, clock gated
//     11 ACTIVE     rail on, clocked
//
// Ports
//   clk            single clock
//   reset_n        asynchronous active-low reset
//   target_state   requested power state, sampled only when idle
//   pwr_ack        power-switch status (1 = rail up), synchronous to clk
//   err_clr        one-cycle pulse clearing err
//   current_state  power state the domain has actually reached
//   busy           sequence in progress
//   clk_en         domain clock gate enable
//   iso_en         isolation clamp enable (1 = isolated)
//   pwr_sw_en      power switch enable
//   ret_save       retention save pulse (RET_CYCLES wide)
//   ret_restore    retention restore pulse (RET_CYCLES wide)
//   ret_valid      retention flops hold valid saved content
//   err            sticky acknowledge-timeout flag
// -----------------------------------------------------------------------------
module pwr_domain_seq #(
    parameter int SETTLE_CYCLES = 4,   // 1..255
    parameter int RET_CYCLES    = 2,   // 1..15
    parameter int ACK_TIMEOUT   = 16   // 2..255
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] target_state,
    input  logic       pwr_ack,
    input  logic       err_clr,
    output logic [1:0] current_state,
    output logic       busy,
    output logic       clk_en,
    output logic       iso_en,
    output logic       pwr_sw_en,
    output logic       ret_save,
    output logic       ret_restore,
    output logic       ret_valid,
    output logic       err
);

    localparam logic [1:0] PS_SHUTDOWN  = 2'b00;
    localparam logic [1:0] PS_DEEPSLEEP = 2'b01;
    localparam logic [1:0] PS_ACTIVE    = 2'b11;

    // Terminal counts: every timed state counts 0 .. N-1.
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] RET_LAST    = 8'(RET_CYCLES - 1);
    localparam logic [7:0] ACK_LAST    = 8'(ACK_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLK_OFF,
        S_ISO_ON,
        S_SAVE,
        S_PSW_OFF,
        S_PSW_ON,
        S_SETTLE,
        S_RESTORE,
        S_ISO_OFF,
        S_CLK_ON,
        S_LATERAL
    } state_t;

    state_t     r_state;
    logic [1:0] r_target;   // target captured in IDLE, frozen for the sequence
    logic [7:0] r_cnt;      // shared by SAVE, RESTORE, SETTLE and the ack waits

    // Bit 1 of the encoding is "rail on" (SLEEP/ACTIVE).
    logic w_cur_on;
    logic w_tgt_on;
    // In both wait states pwr_sw_en already holds the commanded rail level.
    logic w_ack_ok;

    assign w_cur_on = current_state[1];
    assign w_tgt_on = target_state[1];
    assign w_ack_ok = (pwr_ack == pwr_sw_en);

    // NOTE: all state and outputs are updated with non-blocking assignments so
    // every branch below sees the pre-edge values of the registers it reads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_target      <= PS_SHUTDOWN;
            r_cnt         <= '0;
            current_state <= PS_SHUTDOWN;
            busy          <= 1'b0;
            clk_en        <= 1'b0;
            iso_en        <= 1'b1;
            pwr_sw_en     <= 1'b0;
            ret_save      <= 1'b0;
            ret_restore   <= 1'b0;
            ret_valid     <= 1'b0;
            err           <= 1'b0;
        end else begin
            // A timeout later in this block overrides a coincident clear.
            if (err_clr) begin
                err <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (target_state != current_state) begin
                        r_target <= target_state;
                        busy     <= 1'b1;
                        if (w_cur_on && !w_tgt_on) begin
                            r_state <= S_CLK_OFF;
                            clk_en  <= 1'b0;
                        end else if (!w_cur_on && w_tgt_on) begin
                            r_state   <= S_PSW_ON;
                            pwr_sw_en <= 1'b1;
                        end else begin
                            // Same rail level: only the clock gate can differ.
                            r_state <= S_LATERAL;
                            if (w_tgt_on) begin
                                clk_en <= (target_state == PS_ACTIVE);
                            end
                        end
                    end
                end

                S_CLK_OFF: begin
                    r_state <= S_ISO_ON;
                    iso_en  <= 1'b1;
                end

                S_ISO_ON: begin
                    r_cnt <= '0;
                    if (r_target == PS_DEEPSLEEP) begin
                        r_state  <= S_SAVE;
                        ret_save <= 1'b1;
                    end else begin
                        r_state   <= S_PSW_OFF;
                        pwr_sw_en <= 1'b0;
                    end
                end

                S_SAVE: begin
                    if (r_cnt == RET_LAST) begin
                        r_cnt     <= '0;
                        ret_save  <= 1'b0;
                        ret_valid <= 1'b1;
                        r_state   <= S_PSW_OFF;
                        pwr_sw_en <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                S_PSW_OFF, S_PSW_ON: begin
                    if (w_ack_ok) begin
                        r_cnt <= '0;
                        if (r_state == S_PSW_OFF) begin
                            current_state <= r_target;
                            busy          <= 1'b0;
                            r_state       <= S_IDLE;
                            if (r_target == PS_SHUTDOWN) begin
                                ret_valid <= 1'b0;
                            end
                        end else begin
                            r_state <= S_SETTLE;
                        end
                    end else if (r_cnt == ACK_LAST) begin
                        // Switch never answered: park the domain safely off.
                        r_cnt         <= '0;
                        err           <= 1'b1;
                        pwr_sw_en     <= 1'b0;
                        iso_en        <= 1'b1;
                        clk_en        <= 1'b0;
                        ret_save      <= 1'b0;
                        ret_restore   <= 1'b0;
                        ret_valid     <= 1'b0;
                        current_state <= PS_SHUTDOWN;
                        busy          <= 1'b0;
                        r_state       <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                S_SETTLE: begin
                    if (r_cnt == SETTLE_LAST) begin
                        r_cnt <= '0;
                        if (ret_valid) begin
                            r_state     <= S_RESTORE;
                            ret_restore <= 1'b1;
                        end else begin
                            r_state <= S_ISO_OFF;
                            iso_en  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                S_RESTORE: begin
                    if (r_cnt == RET_LAST) begin
                        r_cnt       <= '0;
                        ret_restore <= 1'b0;
                        ret_valid   <= 1'b0;
                        r_state     <= S_ISO_OFF;
                        iso_en      <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                S_ISO_OFF: begin
                    if (r_target == PS_ACTIVE) begin
                        r_state <= S_CLK_ON;
                        clk_en  <= 1'b1;
                    end else begin
                        current_state <= r_target;
                        busy          <= 1'b0;
                        r_state       <= S_IDLE;
                    end
                end

                S_CLK_ON: begin
                    current_state <= r_target;
                    busy          <= 1'b0;
                    r_state       <= S_IDLE;
                end

                S_LATERAL: begin
                    if (r_target == PS_SHUTDOWN) begin
                        ret_valid <= 1'b0;
                    end
                    current_state <= r_target;
                    busy          <= 1'b0;
                    r_state       <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwr_domain_seq.sv
// -----------------------------------------------------------------------------
// tb_pwr_domain_seq
//   Self-checking bench for pwr_domain_seq. A switch responder answers
//   pwr_sw_en after a programmable lag (or holds pwr_ack). Each transaction is
//   compared against a transaction-level model that predicts busy length,
//   retention pulse widths and the settled outputs from the power-state rules.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pwr_domain_seq;

    localparam int SETTLE = 4;
    localparam int RET    = 2;
    localparam int TO     = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] target_state = 2'b00;
    logic       pwr_ack = 1'b0;
    logic       err_clr = 1'b0;
    logic [1:0] current_state;
    logic       busy, clk_en, iso_en, pwr_sw_en;
    logic       ret_save, ret_restore, ret_valid, err;

    pwr_domain_seq #(
        .SETTLE_CYCLES (SETTLE),
        .RET_CYCLES    (RET),
        .ACK_TIMEOUT   (TO)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .target_state  (target_state),
        .pwr_ack       (pwr_ack),
        .err_clr       (err_clr),
        .current_state (current_state),
        .busy          (busy),
        .clk_en        (clk_en),
        .iso_en        (iso_en),
        .pwr_sw_en     (pwr_sw_en),
        .ret_save      (ret_save),
        .ret_restore   (ret_restore),
        .ret_valid     (ret_valid),
        .err           (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Switch responder: pwr_ack equals pwr_sw_en as seen ack_lag negedges ago,
    // so the sequencer waits ack_lag+1 cycles for the rail to respond.
    logic [63:0] sw_hist = '0;
    int          ack_lag = 0;
    bit          ack_hold = 1'b0;

    always @(negedge clk) begin
        sw_hist = {sw_hist[62:0], pwr_sw_en};
        if (!ack_hold) pwr_ack = sw_hist[ack_lag];
    end

    // Reference model state.
    logic [1:0] m_cur = 2'b00;
    logic       m_rv  = 1'b0;
    logic       m_err = 1'b0;

    typedef struct packed {
        int         busy_n;
        int         save_n;
        int         rest_n;
        logic [1:0] cur;
        logic       clk_en;
        logic       iso;
        logic       sw;
        logic       rv;
        logic       err;
    } exp_t;

    // Transaction-level prediction. w = cycles the switch needs to respond.
    function automatic exp_t predict(input logic [1:0] cur, input logic [1:0] tgt,
                                     input logic rv, input logic er, input int w);
        exp_t e;
        bit   ok;
        bit   timed_out;
        ok        = (w <= TO);
        timed_out = 1'b0;
        e.busy_n = 0; e.save_n = 0; e.rest_n = 0;
        e.cur = cur; e.rv = rv; e.err = er;
        if (tgt == cur) begin
            // no action
        end else if (cur[1] == tgt[1]) begin
            e.busy_n = 1;
            e.cur    = tgt;
            if (tgt == 2'b00) e.rv = 1'b0;
        end else if (cur[1]) begin
            e.save_n = (tgt == 2'b01) ? RET : 0;
            e.busy_n = 2 + e.save_n + (ok ? w : TO);
            e.cur    = tgt;
            e.rv     = (tgt == 2'b01);
            timed_out = !ok;
        end else begin
            e.rest_n = (ok && rv) ? RET : 0;
            e.busy_n = ok ? (w + SETTLE + e.rest_n + 1 + ((tgt == 2'b11) ? 1 : 0)) : TO;
            e.cur    = tgt;
            e.rv     = 1'b0;
            timed_out = !ok;
        end
        if (timed_out) begin
            e.cur = 2'b00; e.rv = 1'b0; e.err = 1'b1;
        end
        e.clk_en = (e.cur == 2'b11);
        e.iso    = !e.cur[1];
        e.sw     = e.cur[1];
        return e;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Issues one target, follows the sequence to completion and measures it.
    // Ordering invariants are checked on every busy cycle.
    task automatic run_txn(input logic [1:0] tgt, input int change_at, input logic [1:0] change_tgt,
                           input int clr_at, output int nb, output int ns, output int nr);
        nb = 0; ns = 0; nr = 0;
        @(negedge clk);
        target_state = tgt;
        @(negedge clk);
        while (busy === 1'b1 && nb < 200) begin
            nb++;
            ns += int'(ret_save);
            nr += int'(ret_restore);
            n_checks += 3;
            if ((ret_save & ret_restore) !== 1'b0) begin
                n_errors++;
                $display("FAIL save_restore_overlap: save=%b restore=%b required not both 1", ret_save, ret_restore);
            end
            if ((!pwr_sw_en || !pwr_ack) && iso_en !== 1'b1) begin
                n_errors++;
                $display("FAIL iso_when_unpowered: iso_en=%b required 1 (sw=%b ack=%b)", iso_en, pwr_sw_en, pwr_ack);
            end
            if (clk_en && iso_en !== 1'b0) begin
                n_errors++;
                $display("FAIL clk_while_isolated: iso_en=%b required 0 while clk_en=1", iso_en);
            end
            err_clr = (nb == clr_at);
            if (nb == change_at) target_state = change_tgt;
            @(negedge clk);
        end
        err_clr = 1'b0;
        n_checks++;
        if (nb >= 200) begin
            n_errors++;
            $display("FAIL busy_bound: busy still %b after %0d cycles, required to finish", busy, nb);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle(3);
        n_checks += 9;
        if (current_state !== 2'b00) begin n_errors++; $display("FAIL reset current_state: got %b required 00", current_state); end
        if (busy !== 1'b0)        begin n_errors++; $display("FAIL reset busy: got %b required 0", busy); end
        if (clk_en !== 1'b0)      begin n_errors++; $display("FAIL reset clk_en: got %b required 0", clk_en); end
        if (iso_en !== 1'b1)      begin n_errors++; $display("FAIL reset iso_en: got %b required 1", iso_en); end
        if (pwr_sw_en !== 1'b0)   begin n_errors++; $display("FAIL reset pwr_sw_en: got %b required 0", pwr_sw_en); end
        if (ret_save !== 1'b0)    begin n_errors++; $display("FAIL reset ret_save: got %b required 0", ret_save); end
        if (ret_restore !== 1'b0) begin n_errors++; $display("FAIL reset ret_restore: got %b required 0", ret_restore); end
        if (ret_valid !== 1'b0)   begin n_errors++; $display("FAIL reset ret_valid: got %b required 0", ret_valid); end
        if (err !== 1'b0)         begin n_errors++; $display("FAIL reset err: got %b required 0", err); end
        reset_n = 1'b1;
        idle(3);
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL idle_no_action busy: got %b required 0", busy); end
    endtask

    task automatic test_power_up();
        int nb, ns, nr;
        ack_lag = 2;   // rail answers on the 3rd wait cycle
        run_txn(2'b11, -1, 2'b00, -1, nb, ns, nr);
        n_checks += 6;
        if (nb !== 9)                 begin n_errors++; $display("FAIL up_active busy_cycles: got %0d required 9", nb); end
        if (nr !== 0)                 begin n_errors++; $display("FAIL up_active restore_cycles: got %0d required 0", nr); end
        if (current_state !== 2'b11)  begin n_errors++; $display("FAIL up_active current_state: got %b required 11", current_state); end
        if (clk_en !== 1'b1)          begin n_errors++; $display("FAIL up_active clk_en: got %b required 1", clk_en); end
        if (iso_en !== 1'b0)          begin n_errors++; $display("FAIL up_active iso_en: got %b required 0", iso_en); end
        if (ret_valid !== 1'b0)       begin n_errors++; $display("FAIL up_active ret_valid: got %b required 0", ret_valid); end
        idle(24);
    endtask

    task automatic test_down_deepsleep();
        int nb, ns, nr;
        ack_lag = 0;
        run_txn(2'b01, -1, 2'b00, -1, nb, ns, nr);
        n_checks += 6;
        if (nb !== 5)                begin n_errors++; $display("FAIL down_ds busy_cycles: got %0d required 5", nb); end
        if (ns !== 2)                begin n_errors++; $display("FAIL down_ds save_cycles: got %0d required 2", ns); end
        if (current_state !== 2'b01) begin n_errors++; $display("FAIL down_ds current_state: got %b required 01", current_state); end
        if (ret_valid !== 1'b1)      begin n_errors++; $display("FAIL down_ds ret_valid: got %b required 1", ret_valid); end
        if (pwr_sw_en !== 1'b0)      begin n_errors++; $display("FAIL down_ds pwr_sw_en: got %b required 0", pwr_sw_en); end
        if (iso_en !== 1'b1)         begin n_errors++; $display("FAIL down_ds iso_en: got %b required 1", iso_en); end
        idle(24);
    endtask

    task automatic test_up_restore();
        int nb, ns, nr;
        run_txn(2'b10, -1, 2'b00, -1, nb, ns, nr);
        n_checks += 6;
        if (nb !== 8)                begin n_errors++; $display("FAIL up_sleep busy_cycles: got %0d required 8", nb); end
        if (nr !== 2)                begin n_errors++; $display("FAIL up_sleep restore_cycles: got %0d required 2", nr); end
        if (current_state !== 2'b10) begin n_errors++; $display("FAIL up_sleep current_state: got %b required 10", current_state); end
        if (ret_valid !== 1'b0)      begin n_errors++; $display("FAIL up_sleep ret_valid: got %b required 0", ret_valid); end
        if (iso_en !== 1'b0)         begin n_errors++; $display("FAIL up_sleep iso_en: got %b required 0", iso_en); end
        if (clk_en !== 1'b0)         begin n_errors++; $display("FAIL up_sleep clk_en: got %b required 0", clk_en); end
        idle(24);
    endtask

    task automatic test_timeout();
        int nb, ns, nr;
        run_txn(2'b00, -1, 2'b00, -1, nb, ns, nr);   // SLEEP -> SHUTDOWN
        n_checks += 2;
        if (nb !== 3)                begin n_errors++; $display("FAIL down_sd busy_cycles: got %0d required 3", nb); end
        if (current_state !== 2'b00) begin n_errors++; $display("FAIL down_sd current_state: got %b required 00", current_state); end
        idle(24);
        ack_hold = 1'b1;
        pwr_ack  = 1'b0;
        run_txn(2'b11, -1, 2'b00, -1, nb, ns, nr);
        n_checks += 6;
        if (nb !== TO)               begin n_errors++; $display("FAIL timeout busy_cycles: got %0d required %0d", nb, TO); end
        if (err !== 1'b1)            begin n_errors++; $display("FAIL timeout err: got %b required 1", err); end
        if (pwr_sw_en !== 1'b0)      begin n_errors++; $display("FAIL timeout pwr_sw_en: got %b required 0", pwr_sw_en); end
        if (iso_en !== 1'b1)         begin n_errors++; $display("FAIL timeout iso_en: got %b required 1", iso_en); end
        if (clk_en !== 1'b0)         begin n_errors++; $display("FAIL timeout clk_en: got %b required 0", clk_en); end
        if (current_state !== 2'b00) begin n_errors++; $display("FAIL timeout current_state: got %b required 00", current_state); end
        ack_hold = 1'b0;
        target_state = 2'b00;
        idle(24);
    endtask

    task automatic test_err_clr();
        int nb, ns, nr;
        // err_clr coinciding with a fresh timeout must leave err set.
        ack_hold = 1'b1;
        pwr_ack  = 1'b0;
        run_txn(2'b11, -1, 2'b00, TO, nb, ns, nr);
        n_checks += 2;
        if (nb !== TO)    begin n_errors++; $display("FAIL clr_collision busy_cycles: got %0d required %0d", nb, TO); end
        if (err !== 1'b1) begin n_errors++; $display("FAIL clr_collision err: got %b required 1", err); end
        ack_hold = 1'b0;
        target_state = 2'b00;
        idle(24);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        n_checks++;
        if (err !== 1'b0) begin n_errors++; $display("FAIL err_clr err: got %b required 0", err); end
        idle(2);
        n_checks++;
        if (err !== 1'b0) begin n_errors++; $display("FAIL err_clr sticky_zero: got %b required 0", err); end
    endtask

    task automatic test_midseq_change();
        int nb, ns, nr, nd;
        ack_lag = 0;
        // Busy cycle 3 is inside SETTLE; the new request must wait.
        run_txn(2'b11, 3, 2'b00, -1, nb, ns, nr);
        n_checks += 2;
        if (nb !== 7)                begin n_errors++; $display("FAIL midseq up_busy_cycles: got %0d required 7", nb); end
        if (current_state !== 2'b11) begin n_errors++; $display("FAIL midseq reached: got %b required 11", current_state); end
        @(negedge clk);
        n_checks += 2;
        if (busy !== 1'b1)   begin n_errors++; $display("FAIL midseq restart busy: got %b required 1", busy); end
        if (clk_en !== 1'b0) begin n_errors++; $display("FAIL midseq restart clk_en: got %b required 0", clk_en); end
        nd = 0;
        while (busy === 1'b1 && nd < 200) begin
            nd++;
            @(negedge clk);
        end
        n_checks += 2;
        if (nd !== 3)                begin n_errors++; $display("FAIL midseq down_busy_cycles: got %0d required 3", nd); end
        if (current_state !== 2'b00) begin n_errors++; $display("FAIL midseq final: got %b required 00", current_state); end
        idle(24);
    endtask

    task automatic test_reset_mid();
        int nb, ns, nr;
        run_txn(2'b11, -1, 2'b00, -1, nb, ns, nr);
        idle(24);
        @(negedge clk);
        target_state = 2'b01;
        repeat (3) @(negedge clk);   // CLK_OFF, ISO_ON, first SAVE cycle
        n_checks++;
        if (ret_save !== 1'b1) begin n_errors++; $display("FAIL rstmid in_save ret_save: got %b required 1", ret_save); end
        #2 reset_n = 1'b0;
        #1;
        n_checks += 6;
        if (ret_save !== 1'b0)       begin n_errors++; $display("FAIL rstmid ret_save: got %b required 0", ret_save); end
        if (iso_en !== 1'b1)         begin n_errors++; $display("FAIL rstmid iso_en: got %b required 1", iso_en); end
        if (pwr_sw_en !== 1'b0)      begin n_errors++; $display("FAIL rstmid pwr_sw_en: got %b required 0", pwr_sw_en); end
        if (current_state !== 2'b00) begin n_errors++; $display("FAIL rstmid current_state: got %b required 00", current_state); end
        if (busy !== 1'b0)           begin n_errors++; $display("FAIL rstmid busy: got %b required 0", busy); end
        if (ret_valid !== 1'b0)      begin n_errors++; $display("FAIL rstmid ret_valid: got %b required 0", ret_valid); end
        @(negedge clk);
        target_state = 2'b00;
        @(negedge clk);
        reset_n = 1'b1;
        idle(24);
    endtask

    task automatic test_lateral();
        int nb, ns, nr;
        run_txn(2'b01, -1, 2'b00, -1, nb, ns, nr);   // SHUTDOWN -> DEEPSLEEP
        n_checks += 3;
        if (nb !== 1)                begin n_errors++; $display("FAIL lat_sd_ds busy_cycles: got %0d required 1", nb); end
        if (current_state !== 2'b01) begin n_errors++; $display("FAIL lat_sd_ds current_state: got %b required 01", current_state); end
        if (ret_valid !== 1'b0)      begin n_errors++; $display("FAIL lat_sd_ds ret_valid: got %b required 0", ret_valid); end
        run_txn(2'b00, -1, 2'b00, -1, nb, ns, nr);   // DEEPSLEEP -> SHUTDOWN
        n_checks += 2;
        if (nb !== 1)                begin n_errors++; $display("FAIL lat_ds_sd busy_cycles: got %0d required 1", nb); end
        if (current_state !== 2'b00) begin n_errors++; $display("FAIL lat_ds_sd current_state: got %b required 00", current_state); end
        run_txn(2'b11, -1, 2'b00, -1, nb, ns, nr);
        idle(24);
        run_txn(2'b10, -1, 2'b00, -1, nb, ns, nr);   // ACTIVE -> SLEEP
        n_checks += 3;
        if (nb !== 1)                begin n_errors++; $display("FAIL lat_act_slp busy_cycles: got %0d required 1", nb); end
        if (clk_en !== 1'b0)         begin n_errors++; $display("FAIL lat_act_slp clk_en: got %b required 0", clk_en); end
        if (current_state !== 2'b10) begin n_errors++; $display("FAIL lat_act_slp current_state: got %b required 10", current_state); end
        run_txn(2'b11, -1, 2'b00, -1, nb, ns, nr);   // SLEEP -> ACTIVE
        n_checks += 3;
        if (nb !== 1)                begin n_errors++; $display("FAIL lat_slp_act busy_cycles: got %0d required 1", nb); end
        if (clk_en !== 1'b1)         begin n_errors++; $display("FAIL lat_slp_act clk_en: got %b required 1", clk_en); end
        if (iso_en !== 1'b0)         begin n_errors++; $display("FAIL lat_slp_act iso_en: got %b required 0", iso_en); end
        m_cur = 2'b11; m_rv = 1'b0; m_err = 1'b0;
        idle(24);
    endtask

    task automatic test_random();
        exp_t       e;
        logic [1:0] tgt;
        int         r, lag, nb, ns, nr;
        for (int t = 0; t < 40; t++) begin
            tgt = 2'($urandom_range(0, 3));
            r   = int'($urandom_range(0, 9));
            lag = (r < 6) ? int'($urandom_range(0, 4)) : (13 + r - 6);   // 13..16 probes the timeout edge
            ack_lag = lag;
            e = predict(m_cur, tgt, m_rv, m_err, lag + 1);
            run_txn(tgt, -1, 2'b00, -1, nb, ns, nr);
            n_checks += 9;
            if (nb !== e.busy_n)            begin n_errors++; $display("FAIL rand[%0d] busy_cycles: got %0d required %0d", t, nb, e.busy_n); end
            if (ns !== e.save_n)            begin n_errors++; $display("FAIL rand[%0d] save_cycles: got %0d required %0d", t, ns, e.save_n); end
            if (nr !== e.rest_n)            begin n_errors++; $display("FAIL rand[%0d] restore_cycles: got %0d required %0d", t, nr, e.rest_n); end
            if (current_state !== e.cur)    begin n_errors++; $display("FAIL rand[%0d] current_state: got %b required %b", t, current_state, e.cur); end
            if (clk_en !== e.clk_en)        begin n_errors++; $display("FAIL rand[%0d] clk_en: got %b required %b", t, clk_en, e.clk_en); end
            if (iso_en !== e.iso)           begin n_errors++; $display("FAIL rand[%0d] iso_en: got %b required %b", t, iso_en, e.iso); end
            if (pwr_sw_en !== e.sw)         begin n_errors++; $display("FAIL rand[%0d] pwr_sw_en: got %b required %b", t, pwr_sw_en, e.sw); end
            if (ret_valid !== e.rv)         begin n_errors++; $display("FAIL rand[%0d] ret_valid: got %b required %b", t, ret_valid, e.rv); end
            if (err !== e.err)              begin n_errors++; $display("FAIL rand[%0d] err: got %b required %b", t, err, e.err); end
            m_cur = e.cur; m_rv = e.rv; m_err = e.err;
            target_state = m_cur;
            idle(24);
            if ($urandom_range(0, 3) == 0) begin
                err_clr = 1'b1;
                @(negedge clk);
                err_clr = 1'b0;
                m_err = 1'b0;
                n_checks++;
                if (err !== 1'b0) begin n_errors++; $display("FAIL rand[%0d] err_clr: got %b required 0", t, err); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_down_deepsleep();
        test_up_restore();
        test_timeout();
        test_err_clr();
        test_midseq_change();
        test_reset_mid();
        test_lateral();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
